chrom_eval_engine: RTL

Parametrised chromosome fitness evaluator, the successor to the fixed 8-bit chromosome processing state machine. It drives a sequence of input vectors into an external phenotype circuit and holds each vector for a programmable settle window. During that window it samples the circuit's output against expected/valid masks and accumulates per-output-bit error counts. Zero-error runs are repeated for a retry count, with optional early abort on first error, and every evaluated cycle is logged to a trace memory port.

---
 rtl/chrom_eval_if.sv | 27 ++
 rtl/chrom_eval_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/chrom_eval_if.sv
// Control handshake and trace port of the chromosome evaluator.
// The engine uses the slave modport; whoever drives start/ack uses master.
interface chrom_eval_if #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 15
);
  logic                        iStart;
  logic                        iAck;
  logic                        oReady;
  logic                        oDone;
  logic                        oPass;
  logic                        oTraceWe;
  logic [ADDR_W-1:0]           oTraceAddr;
  logic [IN_W+8+2*OUT_W-1:0]   oTraceData;
  logic                        oTraceOverflow;

  modport slave (
    input  iStart, iAck,
    output oReady, oDone, oPass, oTraceWe, oTraceAddr, oTraceData, oTraceOverflow
  );

  modport master (
    output iStart, iAck,
    input  oReady, oDone, oPass, oTraceWe, oTraceAddr, oTraceData, oTraceOverflow
  );
endinterface

// File: rtl/chrom_eval_engine.sv
// Chromosome fitness evaluator: drives stored vectors into a phenotype circuit,
// samples its outputs after a settle window and accumulates per-bit error counts.
module chrom_eval_engine #(
  parameter int IN_W             = 8,
  parameter int OUT_W            = 8,
  parameter int SEQ_DEPTH        = 64,
  parameter int CNT_W            = 32,
  parameter int ADDR_W           = 15,
  parameter int NUM_RETRIES      = 3,
  parameter int CYCLES_TO_IGNORE = 10
) (
  input  logic                       iClock,
  input  logic                       iReset,
  chrom_eval_if.slave                ctrl,
  input  logic [7:0]                 iSeqLen,
  input  logic [15:0]                iSettleCycles,
  input  logic                       iAbortOnError,
  input  logic [SEQ_DEPTH*IN_W-1:0]  iInputSequence,
  input  logic [SEQ_DEPTH*OUT_W-1:0] iExpectedOutput,
  input  logic [SEQ_DEPTH*OUT_W-1:0] iValidOutput,
  input  logic [OUT_W-1:0]           iDutOut,
  output logic [IN_W-1:0]            oDutIn,
  output logic                       oDutClear,
  output logic [OUT_W*CNT_W-1:0]     oErrorSums,
  output logic [CNT_W+3:0]           oTotalErrors,
  output logic [2:0]                 oState
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    APPLY = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0]       IGNORE_C     = 16'(CYCLES_TO_IGNORE);
  localparam logic [15:0]       MIN_SETTLE_C = 16'(CYCLES_TO_IGNORE + 1);
  localparam logic [7:0]        DEPTH_C      = 8'(SEQ_DEPTH);
  localparam logic [7:0]        RETRIES_C    = 8'(NUM_RETRIES);
  localparam logic [ADDR_W-1:0] ADDR_ONE_C   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE_C    = CNT_W'(1);

  state_t                        state_r, stateNext_s;
  logic [7:0]                    seqLen_r, idx_r, retry_r;
  logic [15:0]                   settle_r, cycle_r;
  logic                          abort_r, pass_r, overflow_r;
  logic [OUT_W-1:0]              flag_r;
  logic [OUT_W-1:0][CNT_W-1:0]   errCnt_r;
  logic [IN_W-1:0]               dutIn_r;
  logic [ADDR_W-1:0]             traceAddr_r;

  logic [IN_W-1:0]               inVec_s;
  logic [OUT_W-1:0]              expVec_s, validVec_s, mismatch_s, hit_s;
  logic                          sampleEn_s, lastCycle_s, lastVec_s, anyHit_s;
  logic                          totalZero_s, retryLeft_s;
  logic [CNT_W+3:0]              total_s;
  logic [7:0]                    lenClamp_s;
  logic [15:0]                   settleClamp_s;

  assign inVec_s     = iInputSequence[idx_r*IN_W +: IN_W];
  assign expVec_s    = iExpectedOutput[idx_r*OUT_W +: OUT_W];
  assign validVec_s  = iValidOutput[idx_r*OUT_W +: OUT_W];
  assign mismatch_s  = (iDutOut ^ expVec_s) & validVec_s;
  assign sampleEn_s  = (cycle_r >= IGNORE_C);
  // hit_s folds the current cycle in so the final settle cycle is sampled too
  assign hit_s       = flag_r | (sampleEn_s ? mismatch_s : {OUT_W{1'b0}});
  assign anyHit_s    = |hit_s;
  assign lastCycle_s = (cycle_r == settle_r - 16'd1);
  assign lastVec_s   = (idx_r == seqLen_r - 8'd1);
  assign totalZero_s = (total_s == {(CNT_W+4){1'b0}});
  assign retryLeft_s = (retry_r < RETRIES_C);

  // Configuration clamping and error total
  always_comb begin
    lenClamp_s = iSeqLen;
    if (iSeqLen == 8'd0) begin
      lenClamp_s = 8'd1;
    end else if (iSeqLen > DEPTH_C) begin
      lenClamp_s = DEPTH_C;
    end else begin
      lenClamp_s = iSeqLen;
    end
    settleClamp_s = (iSettleCycles < MIN_SETTLE_C) ? MIN_SETTLE_C : iSettleCycles;
    total_s = {(CNT_W+4){1'b0}};
    for (int b = 0; b < OUT_W; b++) begin
      total_s = total_s + {4'b0000, errCnt_r[b]};
    end
  end

  // State register
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE:  stateNext_s = ctrl.iStart ? CLEAR : IDLE;
      CLEAR: stateNext_s = LOAD;
      LOAD:  stateNext_s = APPLY;
      APPLY: begin
        if (!lastCycle_s) begin
          stateNext_s = APPLY;
        end else if (abort_r && anyHit_s) begin
          stateNext_s = DONE;
        end else if (lastVec_s) begin
          stateNext_s = CHECK;
        end else begin
          stateNext_s = LOAD;
        end
      end
      CHECK: stateNext_s = (totalZero_s && retryLeft_s) ? LOAD : DONE;
      DONE:  stateNext_s = ctrl.iAck ? IDLE : DONE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Datapath: configuration, vector drive, sampling, counters and trace address
  always_ff @(posedge iClock) begin
    if (iReset) begin
      seqLen_r    <= 8'd0;
      idx_r       <= 8'd0;
      retry_r     <= 8'd0;
      settle_r    <= 16'd0;
      cycle_r     <= 16'd0;
      abort_r     <= 1'b0;
      pass_r      <= 1'b0;
      overflow_r  <= 1'b0;
      flag_r      <= {OUT_W{1'b0}};
      errCnt_r    <= '0;
      dutIn_r     <= {IN_W{1'b0}};
      traceAddr_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (ctrl.iStart) begin
            seqLen_r    <= lenClamp_s;
            settle_r    <= settleClamp_s;
            abort_r     <= iAbortOnError;
            idx_r       <= 8'd0;
            retry_r     <= 8'd0;
            pass_r      <= 1'b0;
            overflow_r  <= 1'b0;
            errCnt_r    <= '0;
            traceAddr_r <= {ADDR_W{1'b0}};
          end
        end
        CLEAR: dutIn_r <= {IN_W{1'b0}};
        LOAD: begin
          dutIn_r <= inVec_s;
          cycle_r <= 16'd0;
          flag_r  <= {OUT_W{1'b0}};
        end
        APPLY: begin
          cycle_r <= cycle_r + 16'd1;
          flag_r  <= hit_s;
          if (!overflow_r) begin
            traceAddr_r <= traceAddr_r + ADDR_ONE_C;
            if (traceAddr_r == {ADDR_W{1'b1}}) begin
              overflow_r <= 1'b1;
            end
          end
          if (lastCycle_s) begin
            for (int b = 0; b < OUT_W; b++) begin
              if (hit_s[b] && (errCnt_r[b] != {CNT_W{1'b1}})) begin
                errCnt_r[b] <= errCnt_r[b] + CNT_ONE_C;
              end
            end
            if (!(abort_r && anyHit_s) && !lastVec_s) begin
              idx_r <= idx_r + 8'd1;
            end
          end
        end
        CHECK: begin
          // A clean run is repeated without re-clearing the phenotype
          if (totalZero_s && retryLeft_s) begin
            retry_r     <= retry_r + 8'd1;
            idx_r       <= 8'd0;
            traceAddr_r <= {ADDR_W{1'b0}};
          end
          pass_r <= totalZero_s && !retryLeft_s;
        end
        DONE: pass_r <= pass_r;
        default: pass_r <= 1'b0;
      endcase
    end
  end

  assign oDutIn              = dutIn_r;
  assign oDutClear           = (state_r == CLEAR);
  assign oErrorSums          = errCnt_r;
  assign oTotalErrors        = total_s;
  assign oState              = state_r;
  assign ctrl.oReady         = (state_r == IDLE);
  assign ctrl.oDone          = (state_r == DONE);
  assign ctrl.oPass          = pass_r;
  assign ctrl.oTraceWe       = (state_r == APPLY) && !overflow_r;
  assign ctrl.oTraceAddr     = traceAddr_r;
  assign ctrl.oTraceData     = {dutIn_r, idx_r, expVec_s, iDutOut};
  assign ctrl.oTraceOverflow = overflow_r;
endmodule
